// File: rtl/fifo_drain.sv
// Drains an upstream FIFO into a ready/valid stream through a 3-entry in-order
// skid buffer, with flush, a delivered-word counter and an asynchronous reset.
module fifo_drain #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t                state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] skid      [3];
    logic [FIFO_WIDTH-1:0] skid_next [3];
    logic [1:0]            occ_next;
    logic [1:0]            wr_idx;
    logic                  do_pop;
    logic                  do_cap;

    // Reads are only issued when the word already owed to us still has a slot.
    assign fifo_rd_en = (state == RUN) && en && !fifo_empty
                        && (({1'b0, occ} + {2'b00, inflight}) < 3'd3);

    assign m_valid = (occ != 2'd0) && (state != FLUSH);
    assign m_data  = skid[0];
    assign busy    = (state != IDLE);

    assign do_pop = m_valid && m_ready;
    assign do_cap = inflight && (state != FLUSH);
    assign wr_idx = occ - {1'b0, do_pop};

    // Head is always skid[0]; a pop shifts down, and a same-cycle capture lands
    // one slot lower so order is preserved.
    // NOTE: combinational blocks use blocking '=' and assign every output first,
    // so no latch is inferred; the clocked block below uses '<=' only.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            skid_next[i] = skid[i];
        end
        if (do_pop) begin
            skid_next[0] = skid[1];
            skid_next[1] = skid[2];
        end
        if (do_cap) begin
            for (int i = 0; i < 3; i++) begin
                if (wr_idx == 2'(i)) begin
                    skid_next[i] = fifo_data_out;
                end
            end
        end
        occ_next = occ + {1'b0, do_cap} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            pop_count <= '0;
            // NOTE: the skid storage is reset too, because m_data must read zero
            // during reset; it is only three words, so this is cheap.
            for (int i = 0; i < 3; i++) begin
                skid[i] <= '0;
            end
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ_next;
            for (int i = 0; i < 3; i++) begin
                skid[i] <= skid_next[i];
            end
            if (do_pop) begin
                pop_count <= pop_count + CNT_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= FLUSH;
                    end else if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= FLUSH;
                    end else if (!en && !inflight) begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    // Wait out any outstanding read so its word is dropped too.
                    if (!flush && !inflight) begin
                        state <= IDLE;
                        occ   <= 2'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: upstream FIFO model, in-order scoreboard,
// directed scenarios and a randomized phase.
module tb_fifo_drain;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b0;
    logic [CW-1:0] pop_count;
    logic          busy;

    fifo_drain #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .flush         (flush),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .pop_count     (pop_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] up_q  [$];   // words still sitting in the upstream FIFO
    logic [W-1:0] exp_q [$];   // words read upstream and owed downstream, in order
    int           model_count = 0;
    int           rd_seen = 0;
    int           acc_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream FIFO: a sampled read returns the head word in the following cycle.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (fifo_rd_en && up_q.size() > 0) begin
                logic [W-1:0] w;
                w = up_q.pop_front();
                fifo_data_out <= w;
                exp_q.push_back(w);
                rd_seen++;
            end
            // Everything read so far, including this edge's read, is discarded.
            if (flush) exp_q.delete();
        end
        fifo_empty <= (up_q.size() == 0);
    end

    // Stream monitor, sampled mid-cycle.
    logic         prev_hold = 1'b0;
    logic         prev_flush = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            model_count = 0;
            prev_hold   = 1'b0;
            prev_flush  = 1'b0;
        end else begin
            if (fifo_rd_en) check("rd_vs_empty", fifo_empty, 0);
            check("occ_bound", exp_q.size() <= 3, 1);
            check("pop_count", pop_count, model_count % (1 << CW));
            if (prev_hold && !prev_flush) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("spurious", m_valid, 0);
                else check("order", m_data, exp_q.pop_front());
                model_count++;
                acc_seen++;
            end
            prev_hold  = m_valid && !m_ready;
            prev_data  = m_data;
            prev_flush = flush;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) up_q.push_back(base + W'(i));
    endtask

    task automatic drain(input string tag);
        int k;
        en = 1'b1; m_ready = 1'b1; flush = 1'b0;
        k = 0;
        while ((up_q.size() != 0 || exp_q.size() != 0) && k < 300) begin
            cyc(1);
            k++;
        end
        check(tag, k < 300, 1);
        cyc(4);
        en = 1'b0;
        cyc(2);
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
        cyc(1);
    endtask

    initial begin
        int first, ndel, cnt, r0, a0, k;

        // Reset values, asserted without any clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_count", pop_count, 0);
        check("rst_busy", busy, 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Empty FIFO: never read, never valid.
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("empty_rd", fifo_rd_en, 0);
            check("empty_valid", m_valid, 0);
        end
        check("empty_busy", busy, 1);
        cyc(1);
        en = 1'b0;
        cyc(3);

        // Stream of 8 words, one per cycle, two cycles after the first read.
        push(8, 16'h0001);
        cyc(2);
        m_ready = 1'b1;
        en = 1'b1;
        first = -1; ndel = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_rd_en && first < 0) first = i;
            if (m_valid && m_ready) begin
                check("stream_data", m_data, ndel + 1);
                check("stream_cycle", i, first + 2 + ndel);
                ndel++;
            end
        end
        check("stream_words", ndel, 8);
        check("stream_count", pop_count, 8);
        en = 1'b0;
        cyc(3);

        // Backpressure: only three reads fit, head word held.
        m_ready = 1'b0;
        push(5, 16'h0100);
        cyc(2);
        r0 = rd_seen;
        en = 1'b1;
        cyc(10);
        check("bp_reads", rd_seen - r0, 3);
        check("bp_occ", exp_q.size(), 3);
        @(negedge clk);
        check("bp_valid", m_valid, 1);
        check("bp_data", m_data, 16'h0100);
        cyc(1);
        m_ready = 1'b1;
        a0 = acc_seen; k = 0;
        while (acc_seen - a0 < 5 && k < 30) begin
            cyc(1);
            k++;
        end
        check("bp_delivered", acc_seen - a0, 5);
        en = 1'b0;
        cyc(3);

        // Flush with two buffered words and one read in flight.
        m_ready = 1'b0;
        push(3, 16'h0200);
        cyc(2);
        en = 1'b1;
        cnt = 0; k = 0;
        while (cnt < 3 && k < 20) begin
            @(negedge clk);
            if (fifo_rd_en) cnt++;
            k++;
        end
        check("flush_reads", cnt, 3);
        @(posedge clk); #1;
        flush = 1'b1; en = 1'b0;
        @(negedge clk);
        check("flush_pre_valid", m_valid, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", m_valid, 0);
        check("flush_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_idle", busy, 0);
        check("flush_idle_valid", m_valid, 0);
        m_ready = 1'b1;
        cyc(3);
        @(negedge clk);
        check("flush_cleared", m_valid, 0);
        cyc(1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 800; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0 && up_q.size() < 8) up_q.push_back(W'($urandom));
            cyc(1);
        end
        drain("rand_drain");

        // Asynchronous reset in the middle of a stream.
        push(20, 16'h0300);
        en = 1'b1; m_ready = 1'b1;
        cyc(6);
        @(negedge clk);
        check("rst_pre_valid", m_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_rd_en", fifo_rd_en, 0);
        check("arst_count", pop_count, 0);
        check("arst_busy", busy, 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        drain("rst_drain");

        // Counter wrap: 17 deliveries on a 4-bit counter.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        push(17, 16'h0400);
        cyc(2);
        drain("wrap_drain");
        check("wrap_count", pop_count, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
